toggle_debouncer: RTL

//   Front-end stage that sits directly upstream of t_flip_flop: turns a raw,

---
 rtl/toggle_debouncer_if.sv | 19 +
 rtl/toggle_debouncer.sv | 118 +++++++++++
 2 files changed

// File: rtl/toggle_debouncer_if.sv
// Button-side bundle of the toggle debouncer: raw level in,
// toggle strobe and debounced level out.
interface toggle_debouncer_if;
  logic btn_in;
  logic t;
  logic btn_state;

  modport master (
    output btn_in,
    input  t,
    input  btn_state
  );

  modport slave (
    input  btn_in,
    output t,
    output btn_state
  );
endinterface

// File: rtl/toggle_debouncer.sv
// Push-button front end: synchronizer, consecutive-sample debounce
// FSM, one-cycle toggle strobe per debounced press.
module toggle_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  toggle_debouncer_if.slave  bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam bit SINGLE = (DEBOUNCE_CYCLES == 1);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] ARM_PRESS   = 2'd1;
  localparam logic [1:0] PRESSED     = 2'd2;
  localparam logic [1:0] ARM_RELEASE = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   t_q, t_d;
  logic                   st_q, st_d;
  logic                   btn_sync;

  assign sync_d   = {sync_q[SYNC_STAGES-2:0], bus.btn_in};
  assign btn_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = 1'b0;
    st_d    = st_q;
    case (state_q)
      IDLE: begin
        st_d = 1'b0;
        if (btn_sync) begin
          // with a single required sample the entry sample qualifies
          if (SINGLE) begin
            state_d = PRESSED;
            cnt_d   = '0;
            t_d     = 1'b1;
            st_d    = 1'b1;
          end else begin
            state_d = ARM_PRESS;
            cnt_d   = ONE;
          end
        end
      end
      ARM_PRESS: begin
        if (!btn_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          t_d     = 1'b1;
          st_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      PRESSED: begin
        st_d = 1'b1;
        if (!btn_sync) begin
          if (SINGLE) begin
            state_d = IDLE;
            cnt_d   = '0;
            st_d    = 1'b0;
          end else begin
            state_d = ARM_RELEASE;
            cnt_d   = ONE;
          end
        end
      end
      ARM_RELEASE: begin
        if (btn_sync) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          st_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        st_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      t_q     <= 1'b0;
      st_q    <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      st_q    <= st_d;
    end
  end

  assign bus.t         = t_q;
  assign bus.btn_state = st_q;

endmodule
